grid_cfg_sequencer: RTL and testbench

- Controller that loads and runs the 32x32 rotatable-tile grid.
- Accepts a byte-stream bitstream from the host and shifts it through the grid scan chain in four passes: vertical-flip plane, horizontal-flip plane, diagonal-flip plane, then initial flop state.
- After each of the three flip passes it strobes the matching configuration-latch selector.
- In RUN it drives the loop-breaker enable and rotates the loop-breaker class.

---
 rtl/grid_ctrl_pkg.sv | 38 +++
 rtl/grid_byte_serializer.sv | 54 +++++
 rtl/grid_cfg_sequencer.sv | 169 ++++++++++++++++
 tb/tb_grid_cfg_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_ctrl_pkg.sv
// Shared types and constants for the rotatable-tile grid configuration controller.
package grid_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam logic [1:0] CFG_NONE = 2'd0;
  localparam logic [1:0] CFG_V    = 2'd1;
  localparam logic [1:0] CFG_H    = 2'd2;
  localparam logic [1:0] CFG_D    = 2'd3;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Latch selector strobed after each flip-plane pass (V, H, then D).
  function automatic logic [1:0] cfg_for_pass(input logic [1:0] pass);
    case (pass)
      2'd0:    return CFG_V;
      2'd1:    return CFG_H;
      default: return CFG_D;
    endcase
  endfunction

  // CRC-16-CCITT, MSB first, one bit per call; init has priority over step.
  function automatic logic [15:0] crc16_next(input logic init, input logic step,
                                             input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    if (init)      return CRC_INIT;
    else if (step) return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    else           return crc;
  endfunction

endpackage

// File: rtl/grid_byte_serializer.sv
// One-byte holding register that turns the host byte stream into scan bits, LSB first.
module grid_byte_serializer
  import grid_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       next_active,
  input  logic       last_bit,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       bit_c,
  output logic       take_c,
  output logic       underflow_c
);

  logic [7:0] hold_q, hold_n, cur_byte;
  logic [2:0] idx_q, idx_n, cur_idx;
  logic       full_q, full_n, accept;

  // An empty register is bypassed so a freshly accepted byte shifts its bit 0 immediately.
  always_comb begin
    accept      = s_valid && s_ready;
    cur_byte    = full_q ? hold_q : s_data;
    cur_idx     = full_q ? idx_q : 3'd0;
    bit_c       = cur_byte[cur_idx];
    take_c      = active && (full_q || accept);
    underflow_c = active && !full_q && !accept;
    hold_n      = hold_q;
    idx_n       = idx_q;
    full_n      = full_q;
    if (take_c) begin
      hold_n = cur_byte;
      idx_n  = cur_idx + 3'd1;
      full_n = !(last_bit || (cur_idx == 3'd7));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= 8'h00;
      idx_q   <= 3'd0;
      full_q  <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      hold_q  <= hold_n;
      idx_q   <= idx_n;
      full_q  <= full_n;
      s_ready <= next_active && !full_n;
    end
  end

endmodule

// File: rtl/grid_cfg_sequencer.sv
// Loads the 32x32 tile grid in four scan passes, strobes config latches, then runs loop breakers.
// Optional readback CRC of grid_sc_out is built when GRID_CFG_READBACK_EN is defined.
module grid_cfg_sequencer #(
  parameter int unsigned CHAIN_LEN = 4096,
  parameter int unsigned LB_PERIOD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        lb_en,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        grid_se,
  output logic        grid_sc,
  output logic [1:0]  grid_cfg,
  output logic        grid_lb,
  output logic [1:0]  grid_lbc,
  input  logic        grid_sc_out,
  output logic        busy,
  output logic        running,
  output logic        err,
  output logic [15:0] readback_crc
);
  import grid_ctrl_pkg::*;

  localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned LB_W  = (LB_PERIOD > 1) ? $clog2(LB_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [LB_W-1:0]  LB_LAST  = LB_W'(LB_PERIOD - 1);

  state_e           state_q, state_n;
  logic [1:0]       pass_q, pass_n;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_n;
  logic [LB_W-1:0]  lb_cnt_q, lb_cnt_n;
  logic             err_n, busy_n, running_n, se_n, sc_n, lb_n;
  logic [1:0]       cfg_n, lbc_n;
  logic             crc_init_c, crc_step_c;
  logic             bit_c, take_c, underflow_c;

  grid_byte_serializer u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (state_q == ST_SHIFT),
    .next_active (state_n == ST_SHIFT),
    .last_bit    (bitcnt_q == LAST_BIT),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .bit_c       (bit_c),
    .take_c      (take_c),
    .underflow_c (underflow_c)
  );

  // Next state plus next registered grid outputs; idle values are the defaults.
  always_comb begin
    state_n    = state_q;
    pass_n     = pass_q;
    bitcnt_n   = bitcnt_q;
    lb_cnt_n   = lb_cnt_q;
    err_n      = err;
    se_n       = 1'b0;
    sc_n       = 1'b0;
    cfg_n      = CFG_NONE;
    lb_n       = 1'b1;
    lbc_n      = 2'd0;
    crc_init_c = 1'b0;
    crc_step_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_SHIFT;
          pass_n     = 2'd0;
          bitcnt_n   = '0;
          err_n      = 1'b0;
          crc_init_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (underflow_c) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (take_c) begin
          se_n       = 1'b1;
          sc_n       = bit_c;
          crc_step_c = 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_n = '0;
            if (pass_q == 2'd3) begin
              state_n  = ST_RUN;
              lb_cnt_n = '0;
            end else begin
              state_n = ST_LATCH;
            end
          end else begin
            bitcnt_n = bitcnt_q + CNT_W'(1);
          end
        end
      end
      ST_LATCH: begin
        se_n    = 1'b1;
        cfg_n   = cfg_for_pass(pass_q);
        pass_n  = pass_q + 2'd1;
        state_n = ST_SHIFT;
      end
      ST_RUN: begin
        // stop wins over a simultaneous start; start is not looked at here
        if (stop) begin
          state_n = ST_IDLE;
        end else begin
          lb_n  = lb_en;
          lbc_n = grid_lbc;
          if (lb_cnt_q == LB_LAST) begin
            lb_cnt_n = '0;
            lbc_n    = grid_lbc + 2'd1;
          end else begin
            lb_cnt_n = lb_cnt_q + LB_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n    = (state_n == ST_SHIFT) || (state_n == ST_LATCH);
    running_n = (state_n == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pass_q   <= 2'd0;
      bitcnt_q <= '0;
      lb_cnt_q <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      running  <= 1'b0;
      grid_se  <= 1'b1;
      grid_sc  <= 1'b0;
      grid_cfg <= CFG_NONE;
      grid_lb  <= 1'b1;
      grid_lbc <= 2'd0;
    end else begin
      state_q  <= state_n;
      pass_q   <= pass_n;
      bitcnt_q <= bitcnt_n;
      lb_cnt_q <= lb_cnt_n;
      err      <= err_n;
      busy     <= busy_n;
      running  <= running_n;
      grid_se  <= se_n;
      grid_sc  <= sc_n;
      grid_cfg <= cfg_n;
      grid_lb  <= lb_n;
      grid_lbc <= lbc_n;
    end
  end

`ifdef GRID_CFG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) readback_crc <= 16'h0000;
    else        readback_crc <= crc16_next(crc_init_c, crc_step_c, readback_crc, grid_sc_out);
  end
`else
  logic unused_readback;
  assign unused_readback = crc_init_c | crc_step_c | grid_sc_out;
  assign readback_crc    = 16'h0000;
`endif

endmodule

// File: tb/tb_grid_cfg_sequencer.sv
// Randomized self-checking bench for grid_cfg_sequencer (CHAIN_LEN=12, LB_PERIOD=4).
module tb_grid_cfg_sequencer;
  localparam int unsigned CHAIN_LEN = 12;
  localparam int unsigned LB_PERIOD = 4;
  localparam int BPP         = (CHAIN_LEN + 7) / 8;
  localparam int PASSES      = 4;
  localparam int LOAD_CYCLES = PASSES * CHAIN_LEN + PASSES - 1;

  logic        clk, rst_n, start, stop, lb_en, s_valid, s_ready;
  logic [7:0]  s_data;
  logic        grid_se, grid_sc, grid_lb, grid_sc_out, busy, running, err;
  logic [1:0]  grid_cfg, grid_lbc;
  logic [15:0] readback_crc;

  int total = 0;
  int bad   = 0;
  logic [7:0] stream[$];
  int bi = 0;

  grid_cfg_sequencer #(.CHAIN_LEN(CHAIN_LEN), .LB_PERIOD(LB_PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lb_en(lb_en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .grid_se(grid_se), .grid_sc(grid_sc), .grid_cfg(grid_cfg), .grid_lb(grid_lb),
    .grid_lbc(grid_lbc), .grid_sc_out(grid_sc_out), .busy(busy), .running(running),
    .err(err), .readback_crc(readback_crc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic present();
    if (bi < stream.size()) begin
      s_valid = 1'b1;
      s_data  = stream[bi];
    end else begin
      s_valid = 1'b0;
      s_data  = 8'h00;
    end
  endtask

  // One clock: note a handshake, step past the edge, offer the next byte.
  task automatic tick();
    logic acc;
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (acc) bi++;
    present();
  endtask

  task automatic load_stream(input int n);
    stream.delete();
    bi = 0;
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom_range(0, 255)));
    present();
  endtask

  function automatic logic stream_bit(input int p, input int b);
    logic [7:0] by;
    by = stream[p * BPP + b / 8];
    return by[b % 8];
  endfunction

  function automatic logic [15:0] crc_ref(input int nbits, input logic din);
    int c, fb;
    c = 32'hFFFF;
    for (int i = 0; i < nbits; i++) begin
      fb = ((c >> 15) & 1) ^ int'(din);
      c  = (c << 1) & 32'hFFFF;
      if (fb != 0) c = c ^ 32'h1021;
    end
    return 16'(c);
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; start = 0; stop = 0; lb_en = 0; grid_sc_out = 0;
    s_valid = 0; s_data = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    total++; if (grid_se !== 1'b1) begin bad++; $display("FAIL reset_se got=%b exp=1", grid_se); end
    total++; if (grid_sc !== 1'b0) begin bad++; $display("FAIL reset_sc got=%b exp=0", grid_sc); end
    total++; if (grid_cfg !== 2'd0) begin bad++; $display("FAIL reset_cfg got=%0d exp=0", grid_cfg); end
    total++; if (grid_lb !== 1'b1) begin bad++; $display("FAIL reset_lb got=%b exp=1", grid_lb); end
    total++; if (grid_lbc !== 2'd0) begin bad++; $display("FAIL reset_lbc got=%0d exp=0", grid_lbc); end
    total++; if ({s_ready, busy, running, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {s_ready, busy, running, err});
    end
    total++; if (readback_crc !== 16'h0000) begin bad++; $display("FAIL reset_crc got=%h exp=0000", readback_crc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_stream(2);
    tick();
    total++; if (grid_se !== 1'b0) begin bad++; $display("FAIL idle_se got=%b exp=0", grid_se); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", s_ready); end
    tick();
    total++; if (bi !== 0) begin bad++; $display("FAIL idle_no_accept got=%0d exp=0", bi); end
  endtask

  task automatic test_happy(input int iter);
    int exp_tok[$];
    int obs_tok[$];
    int first_se, last_se, run_n, o;
    first_se = -1; last_se = -1; run_n = -1;
    load_stream(PASSES * BPP);
    lb_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (busy !== 1'b1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL happy%0d_enter got busy=%b ready=%b exp 1,1", iter, busy, s_ready);
    end
    for (int p = 0; p < PASSES; p++) begin
      for (int b = 0; b < int'(CHAIN_LEN); b++) exp_tok.push_back(int'(stream_bit(p, b)));
      if (p < PASSES - 1) exp_tok.push_back(10 + p + 1);
    end
    for (int n = 1; n <= LOAD_CYCLES + 8; n++) begin
      tick();
      if (grid_se === 1'b1) begin
        obs_tok.push_back((grid_cfg == 2'd0) ? int'(grid_sc) : 10 + int'(grid_cfg));
        if (first_se < 0) first_se = n;
        last_se = n;
      end
      if (running === 1'b1 && run_n < 0) run_n = n;
    end
    total++; if (obs_tok.size() != exp_tok.size()) begin
      bad++; $display("FAIL happy%0d_se_cycles got=%0d exp=%0d", iter, obs_tok.size(), exp_tok.size());
    end
    for (int i = 0; i < exp_tok.size(); i++) begin
      o = (i < obs_tok.size()) ? obs_tok[i] : -1;
      total++; if (o != exp_tok[i]) begin
        bad++; $display("FAIL happy%0d_token[%0d] got=%0d exp=%0d", iter, i, o, exp_tok[i]);
      end
    end
    total++; if (first_se != 1 || last_se != LOAD_CYCLES) begin
      bad++; $display("FAIL happy%0d_se_window got=%0d..%0d exp=1..%0d", iter, first_se, last_se, LOAD_CYCLES);
    end
    total++; if (run_n != LOAD_CYCLES) begin
      bad++; $display("FAIL happy%0d_run_entry got=%0d exp=%0d", iter, run_n, LOAD_CYCLES);
    end
    total++; if (bi != stream.size() || err !== 1'b0) begin
      bad++; $display("FAIL happy%0d_consumed got=%0d err=%b exp=%0d err=0", iter, bi, err, stream.size());
    end
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL happy%0d_stop got=%b exp=0", iter, running); end
  endtask

  task automatic test_run_rotation();
    int n;
    load_stream(PASSES * BPP);
    lb_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (running !== 1'b1 && n < 200) begin tick(); n++; end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL rot_enter got=%b exp=1", running); end
    for (int k = 0; k < 22; k++) begin
      total++; if (grid_lbc !== 2'((k / int'(LB_PERIOD)) % 4)) begin
        bad++; $display("FAIL rot_lbc[%0d] got=%0d exp=%0d", k, grid_lbc, (k / int'(LB_PERIOD)) % 4);
      end
      total++; if (grid_lb !== 1'b1) begin bad++; $display("FAIL rot_lb[%0d] got=%b exp=1", k, grid_lb); end
      if (k >= 1) begin
        total++; if (grid_se !== 1'b0 || grid_cfg !== 2'd0) begin
          bad++; $display("FAIL rot_se[%0d] got se=%b cfg=%0d exp 0,0", k, grid_se, grid_cfg);
        end
      end
      tick();
    end
    lb_en = 1'b0;
    tick();
    total++; if (grid_lb !== 1'b0) begin bad++; $display("FAIL rot_lb_drop got=%b exp=0", grid_lb); end
    total++; if (grid_lbc !== 2'((23 / int'(LB_PERIOD)) % 4)) begin
      bad++; $display("FAIL rot_lbc_hold got=%0d exp=%0d", grid_lbc, (23 / int'(LB_PERIOD)) % 4);
    end
  endtask

  task automatic test_stop_start();
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    total++; if ({running, busy} !== 2'b00) begin bad++; $display("FAIL ss_state got=%b exp=00", {running, busy}); end
    total++; if (grid_lb !== 1'b1 || grid_lbc !== 2'd0) begin
      bad++; $display("FAIL ss_lb got lb=%b lbc=%0d exp 1,0", grid_lb, grid_lbc);
    end
    tick();
    total++; if (busy !== 1'b0 || grid_se !== 1'b0) begin
      bad++; $display("FAIL ss_idle got busy=%b se=%b exp 0,0", busy, grid_se);
    end
  endtask

  task automatic test_underflow();
    int n;
    load_stream(BPP + 1);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 100) begin tick(); n++; end
    total++; if (n != 1 + int'(CHAIN_LEN) + 1 + 8) begin
      bad++; $display("FAIL uf_cycle got=%0d exp=%0d", n, 1 + CHAIN_LEN + 1 + 8);
    end
    total++; if ({err, grid_se, busy, running} !== 4'b1000) begin
      bad++; $display("FAIL uf_state got=%b exp=1000", {err, grid_se, busy, running});
    end
    total++; if (bi != BPP + 1) begin bad++; $display("FAIL uf_consumed got=%0d exp=%0d", bi, BPP + 1); end
  endtask

  task automatic test_restart_reset();
    logic exp_sc;
    load_stream(PASSES * BPP);
    start = 1'b1; tick(); start = 1'b0;
    total++; if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rs_restart got err=%b busy=%b exp 0,1", err, busy);
    end
    for (int n = 1; n <= 2 * (int'(CHAIN_LEN) + 1) + 1 + 5; n++) tick();
    exp_sc = stream_bit(2, 5);
    total++; if (grid_se !== 1'b1 || grid_cfg !== 2'd0 || grid_sc !== exp_sc) begin
      bad++; $display("FAIL rs_pass2_bit5 got se=%b cfg=%0d sc=%b exp 1,0,%b", grid_se, grid_cfg, grid_sc, exp_sc);
    end
    rst_n = 1'b0;
    #1;
    total++; if ({grid_se, grid_sc, grid_cfg, grid_lb, busy} !== 6'b100010) begin
      bad++; $display("FAIL rs_async got=%b exp=100010", {grid_se, grid_sc, grid_cfg, grid_lb, busy});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    total++; if ({grid_se, busy, running, s_ready} !== 4'b0000) begin
      bad++; $display("FAIL rs_idle got=%b exp=0000", {grid_se, busy, running, s_ready});
    end
  endtask

  task automatic test_readback();
    int n;
    logic [15:0] exp_crc;
`ifdef GRID_CFG_READBACK_EN
    exp_crc = crc_ref(PASSES * int'(CHAIN_LEN), 1'b1);
`else
    exp_crc = 16'h0000;
`endif
    grid_sc_out = 1'b1;
    load_stream(PASSES * BPP);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (running !== 1'b1 && n < 200) begin tick(); n++; end
    tick(); tick();
    total++; if (readback_crc !== exp_crc) begin bad++; $display("FAIL crc got=%h exp=%h", readback_crc, exp_crc); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (readback_crc !== exp_crc) begin bad++; $display("FAIL crc_stable got=%h exp=%h", readback_crc, exp_crc); end
    stop = 1'b1; tick(); stop = 1'b0;
    grid_sc_out = 1'b0;
  endtask

  initial begin
    test_reset();
    test_happy(0);
    test_happy(1);
    test_run_rotation();
    test_stop_start();
    test_underflow();
    test_restart_reset();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
